// File: rtl/agex_stage.sv
// AGEX pipeline stage: ALU, branch/jump resolution and a 4-cycle multiply
// that stalls DE while busy. Every output comes straight from a flop.
module agex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        de_valid,
  input  logic [3:0]  de_alu_op,
  input  logic [2:0]  de_br_type,
  input  logic [1:0]  de_jmp,
  input  logic        de_use_imm,
  input  logic [31:0] de_pc,
  input  logic [31:0] de_rs1_val,
  input  logic [31:0] de_rs2_val,
  input  logic [31:0] de_imm,
  input  logic [4:0]  de_rd,
  input  logic        de_wr_reg,
  input  logic [1:0]  de_mem_op,
  input  logic [31:0] de_inst_count,
  output logic        agex_stall,
  output logic        br_mispred,
  output logic [31:0] br_target,
  output logic        out_valid,
  output logic [31:0] out_result,
  output logic [31:0] out_st_data,
  output logic [4:0]  out_rd,
  output logic        out_wr_reg,
  output logic [1:0]  out_mem_op,
  output logic [31:0] out_inst_count
);

  typedef enum logic {IDLE, MUL_BUSY} state_e;

  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [1:0] MUL_CNT = 2'd3;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic        pend_mis_q, pend_mis_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        stall_q, stall_d;
  logic        mis_q, mis_d;
  logic [31:0] tgt_q, tgt_d;
  logic        valid_q, valid_d;
  logic [31:0] result_q, result_d;
  logic [31:0] st_q, st_d;
  logic [4:0]  rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [1:0]  mem_q, mem_d;
  logic [31:0] ic_q, ic_d;

  logic [31:0] op_b, alu_res, result, target, mul_prod;
  logic        jmp_link, taken, mispred, is_mul;

  // Combinational execute of the instruction currently presented by DE
  always_comb begin
    op_b     = de_use_imm ? de_imm : de_rs2_val;
    jmp_link = (de_jmp == 2'd1) || (de_jmp == 2'd2);
    alu_res  = 32'd0;
    case (de_alu_op)
      4'd0:  alu_res = de_rs1_val + op_b;
      4'd1:  alu_res = de_rs1_val - op_b;
      4'd2:  alu_res = de_rs1_val & op_b;
      4'd3:  alu_res = de_rs1_val | op_b;
      4'd4:  alu_res = de_rs1_val ^ op_b;
      4'd5:  alu_res = {31'd0, $signed(de_rs1_val) < $signed(op_b)};
      4'd6:  alu_res = {31'd0, de_rs1_val < op_b};
      4'd7:  alu_res = de_rs1_val << op_b[4:0];
      4'd8:  alu_res = de_rs1_val >> op_b[4:0];
      4'd9:  alu_res = $unsigned($signed(de_rs1_val) >>> op_b[4:0]);
      4'd11: alu_res = de_imm;
      4'd12: alu_res = de_pc + de_imm;
      default: alu_res = 32'd0;
    endcase
    taken = 1'b0;
    case (de_br_type)
      3'd1: taken = (de_rs1_val == de_rs2_val);
      3'd2: taken = (de_rs1_val != de_rs2_val);
      3'd3: taken = ($signed(de_rs1_val) <  $signed(de_rs2_val));
      3'd4: taken = ($signed(de_rs1_val) >= $signed(de_rs2_val));
      3'd5: taken = (de_rs1_val <  de_rs2_val);
      3'd6: taken = (de_rs1_val >= de_rs2_val);
      default: taken = 1'b0;
    endcase
    mispred  = taken || jmp_link;
    target   = (de_jmp == 2'd2) ? ((de_rs1_val + de_imm) & ~32'd1) : (de_pc + de_imm);
    result   = jmp_link ? (de_pc + 32'd4) : alu_res;
    is_mul   = (de_alu_op == OP_MUL) && !jmp_link;
    mul_prod = mul_a_q * mul_b_q;
  end

  // Next-state: accept in IDLE, count down the multiply in MUL_BUSY
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    pend_mis_d = pend_mis_q;
    pend_tgt_d = pend_tgt_q;
    mis_d      = 1'b0;
    tgt_d      = tgt_q;
    valid_d    = 1'b0;
    result_d   = result_q;
    st_d       = st_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    mem_d      = mem_q;
    ic_d       = ic_q;
    case (state_q)
      IDLE: begin
        if (de_valid) begin
          st_d  = de_rs2_val;
          rd_d  = de_rd;
          wr_d  = de_wr_reg;
          mem_d = de_mem_op;
          ic_d  = de_inst_count;
          if (is_mul) begin
            state_d    = MUL_BUSY;
            cnt_d      = MUL_CNT;
            mul_a_d    = de_rs1_val;
            mul_b_d    = de_rs2_val;
            pend_mis_d = mispred;
            pend_tgt_d = target;
          end else begin
            valid_d  = 1'b1;
            result_d = result;
            mis_d    = mispred;
            if (mispred) tgt_d = target;
          end
        end
      end
      MUL_BUSY: begin
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          state_d  = IDLE;
          valid_d  = 1'b1;
          result_d = mul_prod;
          // A redirect on a multiply is deferred so it lines up with its result
          mis_d    = pend_mis_q;
          if (pend_mis_q) tgt_d = pend_tgt_q;
        end
      end
      default: state_d = IDLE;
    endcase
    stall_d = (state_d == MUL_BUSY);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      mul_a_q    <= 32'd0;
      mul_b_q    <= 32'd0;
      pend_mis_q <= 1'b0;
      pend_tgt_q <= 32'd0;
      stall_q    <= 1'b0;
      mis_q      <= 1'b0;
      tgt_q      <= 32'd0;
      valid_q    <= 1'b0;
      result_q   <= 32'd0;
      st_q       <= 32'd0;
      rd_q       <= 5'd0;
      wr_q       <= 1'b0;
      mem_q      <= 2'd0;
      ic_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      pend_mis_q <= pend_mis_d;
      pend_tgt_q <= pend_tgt_d;
      stall_q    <= stall_d;
      mis_q      <= mis_d;
      tgt_q      <= tgt_d;
      valid_q    <= valid_d;
      result_q   <= result_d;
      st_q       <= st_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      mem_q      <= mem_d;
      ic_q       <= ic_d;
    end
  end

  assign agex_stall     = stall_q;
  assign br_mispred     = mis_q;
  assign br_target      = tgt_q;
  assign out_valid      = valid_q;
  assign out_result     = result_q;
  assign out_st_data    = st_q;
  assign out_rd         = rd_q;
  assign out_wr_reg     = wr_q;
  assign out_mem_op     = mem_q;
  assign out_inst_count = ic_q;

endmodule

// File: tb/tb_agex_stage.sv
// Bench for agex_stage: vector table plus multiply/reset sequences, with a
// queue of expected results popped whenever the stage raises out_valid.
module tb_agex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        de_valid;
  logic [3:0]  de_alu_op;
  logic [2:0]  de_br_type;
  logic [1:0]  de_jmp;
  logic        de_use_imm;
  logic [31:0] de_pc, de_rs1_val, de_rs2_val, de_imm;
  logic [4:0]  de_rd;
  logic        de_wr_reg;
  logic [1:0]  de_mem_op;
  logic [31:0] de_inst_count;
  logic        agex_stall, br_mispred, out_valid, out_wr_reg;
  logic [31:0] br_target, out_result, out_st_data, out_inst_count;
  logic [4:0]  out_rd;
  logic [1:0]  out_mem_op;

  agex_stage dut (
    .clk(clk), .reset(reset), .de_valid(de_valid), .de_alu_op(de_alu_op),
    .de_br_type(de_br_type), .de_jmp(de_jmp), .de_use_imm(de_use_imm),
    .de_pc(de_pc), .de_rs1_val(de_rs1_val), .de_rs2_val(de_rs2_val),
    .de_imm(de_imm), .de_rd(de_rd), .de_wr_reg(de_wr_reg),
    .de_mem_op(de_mem_op), .de_inst_count(de_inst_count),
    .agex_stall(agex_stall), .br_mispred(br_mispred), .br_target(br_target),
    .out_valid(out_valid), .out_result(out_result), .out_st_data(out_st_data),
    .out_rd(out_rd), .out_wr_reg(out_wr_reg), .out_mem_op(out_mem_op),
    .out_inst_count(out_inst_count)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] res, st, ic, tgt;
    logic [4:0]  rd;
    logic        wr, mis;
    logic [1:0]  mem;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  br;
    logic [1:0]  jmp;
    logic        ui;
    logic [31:0] pc, a, b, imm, res;
    logic        mis;
    logic [31:0] tgt;
  } vec_t;

  exp_t        sb[$];
  vec_t        vt[23];
  int          total = 0;
  int          bad = 0;
  logic [31:0] tgt_hold = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Advance one edge, then check outputs against the scoreboard head
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("result",     out_result,           e.res);
        chk("st_data",    out_st_data,          e.st);
        chk("rd",         32'(out_rd),          32'(e.rd));
        chk("wr_reg",     32'(out_wr_reg),      32'(e.wr));
        chk("mem_op",     32'(out_mem_op),      32'(e.mem));
        chk("inst_count", out_inst_count,       e.ic);
        chk("mispred",    32'(br_mispred),      32'(e.mis));
        if (e.mis) tgt_hold = e.tgt;
      end
    end else begin
      chk("mispred_no_valid", 32'(br_mispred), 32'd0);
    end
    chk("br_target", br_target, tgt_hold);
  endtask

  task automatic drive(input logic [3:0] op, input logic [2:0] br, input logic [1:0] jmp,
                       input logic ui, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic [4:0] rd,
                       input logic wr, input logic [1:0] mem, input logic [31:0] ic,
                       input logic [31:0] res, input logic mis, input logic [31:0] tgt);
    exp_t e;
    de_valid = 1'b1; de_alu_op = op; de_br_type = br; de_jmp = jmp; de_use_imm = ui;
    de_pc = pc; de_rs1_val = a; de_rs2_val = b; de_imm = imm;
    de_rd = rd; de_wr_reg = wr; de_mem_op = mem; de_inst_count = ic;
    e.res = res; e.st = b; e.ic = ic; e.tgt = tgt; e.rd = rd; e.wr = wr; e.mis = mis; e.mem = mem;
    sb.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"},  32'(out_valid),  32'd0);
    chk({tag, "_stall"},  32'(agex_stall), 32'd0);
    chk({tag, "_mispred"}, 32'(br_mispred), 32'd0);
    chk({tag, "_result"}, out_result,      32'd0);
    chk({tag, "_target"}, br_target,       32'd0);
    chk({tag, "_rd"},     32'(out_rd),     32'd0);
  endtask

  initial begin
    //        op     br    jmp   ui    pc            a             b             imm           res           mis   tgt
    vt[0]  = '{4'd0, 3'd0, 2'd0, 1'b1, 32'h0,        32'hFFFFFFFF, 32'h0,        32'h2,        32'h1,        1'b0, 32'h0};
    vt[1]  = '{4'd9, 3'd0, 2'd0, 1'b0, 32'h0,        32'h80000000, 32'h24,       32'h0,        32'hF8000000, 1'b0, 32'h0};
    vt[2]  = '{4'd6, 3'd0, 2'd0, 1'b0, 32'h0,        32'h1,        32'hFFFFFFFF, 32'h0,        32'h1,        1'b0, 32'h0};
    vt[3]  = '{4'd0, 3'd3, 2'd0, 1'b0, 32'h100,      32'hFFFFFFFF, 32'h0,        32'h20,       32'hFFFFFFFF, 1'b1, 32'h120};
    vt[4]  = '{4'd0, 3'd4, 2'd0, 1'b0, 32'h100,      32'hFFFFFFFF, 32'h0,        32'h20,       32'hFFFFFFFF, 1'b0, 32'h0};
    vt[5]  = '{4'd0, 3'd5, 2'd0, 1'b0, 32'h100,      32'hFFFFFFFF, 32'h0,        32'h20,       32'hFFFFFFFF, 1'b0, 32'h0};
    vt[6]  = '{4'd0, 3'd0, 2'd2, 1'b0, 32'h40,       32'h203,      32'h0,        32'h4,        32'h44,       1'b1, 32'h206};
    vt[7]  = '{4'd1, 3'd0, 2'd0, 1'b0, 32'h0,        32'h5,        32'h7,        32'h0,        32'hFFFFFFFE, 1'b0, 32'h0};
    vt[8]  = '{4'd2, 3'd1, 2'd0, 1'b0, 32'h300,      32'hF0F0,     32'hF0F0,     32'hFFFFFFFC, 32'hF0F0,     1'b1, 32'h2FC};
    vt[9]  = '{4'd3, 3'd2, 2'd0, 1'b0, 32'h300,      32'hF0F0,     32'hF0F0,     32'h8,        32'hF0F0,     1'b0, 32'h0};
    vt[10] = '{4'd13, 3'd0, 2'd1, 1'b0, 32'h1000,    32'h0,        32'h0,        32'hFFFFFFF0, 32'h1004,     1'b1, 32'hFF0};
    vt[11] = '{4'd11, 3'd0, 2'd0, 1'b1, 32'h0,       32'hFFFF,     32'h0,        32'h12345000, 32'h12345000, 1'b0, 32'h0};
    vt[12] = '{4'd12, 3'd0, 2'd0, 1'b1, 32'h2000,    32'h0,        32'h0,        32'h1000,     32'h3000,     1'b0, 32'h0};
    vt[13] = '{4'd14, 3'd0, 2'd0, 1'b0, 32'h0,       32'h5,        32'h5,        32'h0,        32'h0,        1'b0, 32'h0};
    vt[14] = '{4'd7, 3'd0, 2'd0, 1'b1, 32'h0,        32'h1,        32'h0,        32'h3F,       32'h80000000, 1'b0, 32'h0};
    vt[15] = '{4'd5, 3'd0, 2'd0, 1'b0, 32'h0,        32'hFFFFFFFF, 32'h1,        32'h0,        32'h1,        1'b0, 32'h0};
    vt[16] = '{4'd4, 3'd0, 2'd0, 1'b0, 32'h0,        32'hFF00FF00, 32'h0FF00FF0, 32'h0,        32'hF0F0F0F0, 1'b0, 32'h0};
    vt[17] = '{4'd8, 3'd0, 2'd0, 1'b0, 32'h0,        32'h80000000, 32'h4,        32'h0,        32'h08000000, 1'b0, 32'h0};
    vt[18] = '{4'd0, 3'd7, 2'd3, 1'b0, 32'h500,      32'h1,        32'h2,        32'h8,        32'h3,        1'b0, 32'h0};
    vt[19] = '{4'd0, 3'd6, 2'd0, 1'b0, 32'h600,      32'h0,        32'h1,        32'h10,       32'h1,        1'b0, 32'h0};
    vt[20] = '{4'd0, 3'd5, 2'd0, 1'b0, 32'h600,      32'h0,        32'h1,        32'h10,       32'h1,        1'b1, 32'h610};
    vt[21] = '{4'd0, 3'd1, 2'd0, 1'b1, 32'h680,      32'h5,        32'h6,        32'h5,        32'hA,        1'b0, 32'h0};
    vt[22] = '{4'd0, 3'd4, 2'd0, 1'b0, 32'h700,      32'h0,        32'hFFFFFFFF, 32'h4,        32'hFFFFFFFF, 1'b1, 32'h704};

    de_valid = 1'b0; de_alu_op = 4'd0; de_br_type = 3'd0; de_jmp = 2'd0; de_use_imm = 1'b0;
    de_pc = 32'd0; de_rs1_val = 32'd0; de_rs2_val = 32'd0; de_imm = 32'd0;
    de_rd = 5'd0; de_wr_reg = 1'b0; de_mem_op = 2'd0; de_inst_count = 32'd0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2 chk_zero("reset");
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b1;

    // Back-to-back single-cycle instructions from the table
    for (int i = 0; i < 23; i++) begin
      drive(vt[i].op, vt[i].br, vt[i].jmp, vt[i].ui, vt[i].pc, vt[i].a, vt[i].b, vt[i].imm,
            5'(i + 5), i[0], 2'(i), 32'(i * 3 + 100), vt[i].res, vt[i].mis, vt[i].tgt);
      tick();
      chk("latency_valid", 32'(out_valid), 32'd1);
    end
    de_valid = 1'b0;
    tick();
    chk("idle_valid", 32'(out_valid), 32'd0);

    // Multiply followed by an ADD held on de_valid through the stall
    drive(4'd10, 3'd0, 2'd0, 1'b0, 32'h0, 32'h10000, 32'h10001, 32'h0,
          5'd7, 1'b1, 2'd2, 32'd999, 32'h00010000, 1'b0, 32'h0);
    tick();
    chk("mul_e0_valid", 32'(out_valid), 32'd0);
    chk("mul_e0_stall", 32'(agex_stall), 32'd1);
    drive(4'd0, 3'd0, 2'd0, 1'b0, 32'h0, 32'h3, 32'h4, 32'h0,
          5'd9, 1'b1, 2'd0, 32'd1000, 32'h7, 1'b0, 32'h0);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("mul_busy_valid", 32'(out_valid), 32'd0);
      chk("mul_busy_stall", 32'(agex_stall), 32'd1);
    end
    tick();
    chk("mul_done_valid", 32'(out_valid), 32'd1);
    chk("mul_done_stall", 32'(agex_stall), 32'd0);
    tick();
    chk("held_add_valid", 32'(out_valid), 32'd1);
    de_valid = 1'b0;
    tick();
    chk("no_dup_valid", 32'(out_valid), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Reset in the middle of a multiply abandons it
    drive(4'd10, 3'd0, 2'd0, 1'b0, 32'h0, 32'h6, 32'h7, 32'h0,
          5'd3, 1'b1, 2'd1, 32'd2000, 32'd42, 1'b0, 32'h0);
    tick();
    de_valid = 1'b0;
    tick();
    tick();
    #2 reset = 1'b0;
    #1 chk_zero("midmul_reset");
    sb.delete();
    tgt_hold = 32'd0;
    @(posedge clk);
    #1 reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("post_reset_valid", 32'(out_valid), 32'd0);
    end
    drive(4'd0, 3'd0, 2'd0, 1'b1, 32'h0, 32'h10, 32'h0, 32'h5,
          5'd11, 1'b1, 2'd3, 32'd3000, 32'h15, 1'b0, 32'h0);
    tick();
    chk("post_reset_add_valid", 32'(out_valid), 32'd1);
    de_valid = 1'b0;
    tick();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
